// File: rtl/dds_freq_meter.sv
// dds_freq_meter: measures the DDS output frequency by counting rising zero crossings
// (with hysteresis) over a 2^GATE_LOG2-cycle gate and rebuilding an FCW estimate.
module dds_freq_meter #(
    parameter int DATA_W    = 16,
    parameter int FCW_W     = 24,
    parameter int GATE_LOG2 = 20,
    parameter int HYST      = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    sine_in,
    input  logic                 sample_en,
    input  logic                 start,
    input  logic                 continuous,
    output logic [FCW_W-1:0]     fcw_est,
    output logic [GATE_LOG2:0]   crossings,
    output logic                 meas_valid,
    output logic                 busy,
    output logic                 overflow
);
    localparam int SHIFT = FCW_W - GATE_LOG2;
    localparam logic signed [DATA_W-1:0] POS_TH = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] NEG_TH = -POS_TH;

    typedef enum logic [1:0] {POL_UNK, POL_POS, POL_NEG} pol_t;
    typedef enum logic {IDLE, GATE} state_t;

    pol_t                 pol_q, pol_d;
    state_t               state_q, state_d;
    logic                 cross_q, cross_d;
    logic [GATE_LOG2-1:0] gate_q, gate_d;
    logic [GATE_LOG2:0]   cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic [FCW_W-1:0]     fcw_q, fcw_d;
    logic [GATE_LOG2:0]   crossings_q, crossings_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;

    logic signed [DATA_W-1:0] s;
    logic                     hi, lo, last, cnt_full, cnt_ovf, est_ovf;
    logic [GATE_LOG2:0]       cnt_inc;
    logic [FCW_W:0]           est_wide;

    assign s        = $signed(sine_in);
    assign hi       = s >= POS_TH;
    assign lo       = s <= NEG_TH;
    assign last     = gate_q == '1;
    assign cnt_full = cnt_q == '1;
    // Count including this cycle's pulse, so a crossing in the final cycle still lands.
    assign cnt_inc  = (cross_q && !cnt_full) ? cnt_q + 1'b1 : cnt_q;
    assign cnt_ovf  = sat_q || (cross_q && cnt_full);
    assign est_wide = (FCW_W+1)'(cnt_inc) << SHIFT;
    assign est_ovf  = est_wide[FCW_W];

    always_comb begin
        pol_d   = !sample_en ? pol_q : hi ? POL_POS : lo ? POL_NEG : pol_q;
        cross_d = sample_en && hi && (pol_q == POL_NEG);
    end

    always_comb begin
        state_d     = state_q;
        gate_d      = gate_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        fcw_d       = fcw_q;
        crossings_d = crossings_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;
        if (state_q == IDLE) begin
            if (start || continuous) begin
                state_d = GATE;
                gate_d  = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        end else begin
            gate_d = gate_q + 1'b1;
            cnt_d  = cnt_inc;
            sat_d  = cnt_ovf;
            if (last) begin
                valid_d     = 1'b1;
                crossings_d = cnt_inc;
                fcw_d       = est_ovf ? '1 : est_wide[FCW_W-1:0];
                ovf_d       = cnt_ovf || est_ovf;
                state_d     = continuous ? GATE : IDLE;
                gate_d      = '0;
                cnt_d       = '0;
                sat_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pol_q       <= POL_UNK;
            state_q     <= IDLE;
            cross_q     <= 1'b0;
            gate_q      <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            fcw_q       <= '0;
            crossings_q <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            pol_q       <= pol_d;
            state_q     <= state_d;
            cross_q     <= cross_d;
            gate_q      <= gate_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            fcw_q       <= fcw_d;
            crossings_q <= crossings_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign fcw_est    = fcw_q;
    assign crossings  = crossings_q;
    assign meas_valid = valid_q;
    assign overflow   = ovf_q;
    assign busy       = state_q == GATE;
endmodule
